// File: rtl/mux_arb_n.sv
// N-channel mux/arbiter with direct-select or round-robin grant and a registered output stage.
// Define MUX_ARB_LOCK_EN to add the iLock port and round-robin channel locking.
module mux_arb_n #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N     = 8,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] iC,
  input  logic [N-1:0]       iValid,
  output logic [N-1:0]       oAck,
  input  logic               iMode,
  input  logic [SEL_W-1:0]   iSel,
  output logic [WIDTH-1:0]   oZ,
  output logic [SEL_W-1:0]   oChan,
  output logic               oValid,
  input  logic               iReady
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic               iLock
`endif
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic             gnt_valid;
  logic             load_en;
  logic [WIDTH-1:0] sel_data;
  int unsigned      off;
  int unsigned      best_off;

`ifdef MUX_ARB_LOCK_EN
  logic             lock_held;
  logic [SEL_W-1:0] lock_chan;
`endif

  assign load_en = ~oValid | iReady;

  // Grant selection: direct index, or first requester at or after ptr (wrapping).
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    off       = 0;
    best_off  = N;
    if (!iMode) begin
      for (int k = 0; k < int'(N); k++) begin
        if (SEL_W'(k) == iSel && iValid[k]) begin
          gnt       = SEL_W'(k);
          gnt_valid = 1'b1;
        end
      end
`ifdef MUX_ARB_LOCK_EN
    end else if (iLock && lock_held) begin
      // Locked: only the last-granted channel may win.
      for (int k = 0; k < int'(N); k++) begin
        if (SEL_W'(k) == lock_chan && iValid[k]) begin
          gnt       = SEL_W'(k);
          gnt_valid = 1'b1;
        end
      end
`endif
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        if (iValid[k]) begin
          off = (32'(k) >= 32'(ptr)) ? 32'(k) - 32'(ptr) : 32'(k) + N - 32'(ptr);
          if (off < best_off) begin
            best_off  = off;
            gnt       = SEL_W'(k);
            gnt_valid = 1'b1;
          end
        end
      end
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (SEL_W'(k) == gnt) sel_data = iC[k*WIDTH +: WIDTH];
    end
  end

  assign oAck = (!rst && load_en && gnt_valid) ? (N'(1) << gnt) : '0;

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      oZ     <= '0;
      oChan  <= '0;
      oValid <= 1'b0;
      ptr    <= '0;
    end else if (load_en) begin
      if (gnt_valid) begin
        oZ     <= sel_data;
        oChan  <= gnt;
        oValid <= 1'b1;
        if (iMode) ptr <= (32'(gnt) == N - 1) ? '0 : gnt + SEL_W'(1);
      end else begin
        oValid <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_LOCK_EN
  // Lock is taken on a loaded round-robin grant and dropped as soon as iLock falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_held <= 1'b0;
      lock_chan <= '0;
    end else if (!iLock) begin
      lock_held <= 1'b0;
    end else if (iMode && load_en && gnt_valid) begin
      lock_held <= 1'b1;
      lock_chan <= gnt;
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Self-checking bench for mux_arb_n: N=8 instance against a behavioural model, N=6 for out-of-range select.
module tb_mux_arb_n;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] c;
  logic [7:0]   valid;
  logic [7:0]   ack;
  logic         mode;
  logic [2:0]   sel;
  logic [31:0]  z;
  logic [2:0]   chan;
  logic         ov;
  logic         ready;
`ifdef MUX_ARB_LOCK_EN
  logic         lock;
`endif

  logic [47:0]  c6;
  logic [5:0]   valid6;
  logic [5:0]   ack6;
  logic         mode6;
  logic [2:0]   sel6;
  logic [7:0]   z6;
  logic [2:0]   chan6;
  logic         ov6;
  logic         ready6;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] m_z;
  logic [2:0]  m_chan;
  logic [2:0]  m_ptr;
  logic        m_valid;
  logic        m_lock;
  logic [2:0]  m_lchan;

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(32), .N(8)) dut (
    .clk(clk), .rst(rst), .iC(c), .iValid(valid), .oAck(ack), .iMode(mode),
    .iSel(sel), .oZ(z), .oChan(chan), .oValid(ov), .iReady(ready)
`ifdef MUX_ARB_LOCK_EN
    , .iLock(lock)
`endif
  );

  mux_arb_n #(.WIDTH(8), .N(6)) dut6 (
    .clk(clk), .rst(rst), .iC(c6), .iValid(valid6), .oAck(ack6), .iMode(mode6),
    .iSel(sel6), .oZ(z6), .oChan(chan6), .oValid(ov6), .iReady(ready6)
`ifdef MUX_ARB_LOCK_EN
    , .iLock(1'b0)
`endif
  );

  // One clock of the N=8 DUT: check oAck before the edge, registered outputs after it.
  task automatic cycle(input string name);
    logic       ld;
    int         g;
    int         ch;
    logic [7:0] exp_ack;
    logic       lk;
    lk = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lk = lock;
`endif
    ld = !m_valid || ready;
    g  = -1;
    if (!mode) begin
      if (valid[sel]) g = int'(sel);
    end else if (lk && m_lock) begin
      if (valid[m_lchan]) g = int'(m_lchan);
    end else begin
      for (int o = 0; o < 8; o++) begin
        ch = (int'(m_ptr) + o) % 8;
        if (g < 0 && valid[ch]) g = ch;
      end
    end
    exp_ack = (!rst && ld && g >= 0) ? (8'd1 << g) : 8'd0;
    #1;
    tests++;
    if (ack !== exp_ack) begin
      fails++;
      $display("FAIL %s ack: got %h expected %h", name, ack, exp_ack);
    end
    @(posedge clk);
    if (rst) begin
      m_z = '0; m_chan = '0; m_valid = 1'b0; m_ptr = '0; m_lock = 1'b0; m_lchan = '0;
    end else begin
      if (!lk) m_lock = 1'b0;
      else if (mode && ld && g >= 0) begin m_lock = 1'b1; m_lchan = 3'(g); end
      if (ld) begin
        if (g >= 0) begin
          m_z = c[g*32 +: 32]; m_chan = 3'(g); m_valid = 1'b1;
          if (mode) m_ptr = 3'((g + 1) % 8);
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    #1;
    tests++;
    if (ov !== m_valid || (m_valid && (z !== m_z || chan !== m_chan))) begin
      fails++;
      $display("FAIL %s out: got v=%b z=%h ch=%0d expected v=%b z=%h ch=%0d",
               name, ov, z, chan, m_valid, m_z, m_chan);
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < 8; k++) c[k*32 +: 32] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle("reset");
    tests++;
    if (z !== 32'd0 || chan !== 3'd0 || ov !== 1'b0 || ov6 !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: got z=%h ch=%0d v=%b v6=%b expected 0", z, chan, ov, ov6);
    end
    rst = 1'b0;
  endtask

  task automatic test_direct();
    mode = 1'b0; sel = 3'd5; valid = 8'h20; ready = 1'b1;
    c[5*32 +: 32] = 32'hDEADBEEF;
    #1;
    tests++;
    if (ack !== 8'h20) begin
      fails++;
      $display("FAIL direct_ack: got %h expected 20", ack);
    end
    cycle("direct");
    tests++;
    if (z !== 32'hDEADBEEF || chan !== 3'd5 || ov !== 1'b1) begin
      fails++;
      $display("FAIL direct_out: got z=%h ch=%0d v=%b expected deadbeef 5 1", z, chan, ov);
    end
    for (int i = 0; i < 20; i++) begin
      rand_data();
      sel = 3'($urandom_range(0, 7)); valid = 8'($urandom); ready = 1'($urandom);
      cycle("direct_rand");
    end
  endtask

  task automatic test_out_of_range();
    mode6 = 1'b0; sel6 = 3'd7; valid6 = 6'h3F; ready6 = 1'b1;
    c6 = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    #1;
    tests++;
    if (ack6 !== 6'h00) begin
      fails++;
      $display("FAIL oor_ack: got %h expected 00", ack6);
    end
    @(posedge clk); #1;
    tests++;
    if (ov6 !== 1'b0) begin
      fails++;
      $display("FAIL oor_valid: got %b expected 0", ov6);
    end
    sel6 = 3'd2;
    #1;
    tests++;
    if (ack6 !== 6'h04) begin
      fails++;
      $display("FAIL in_range_ack: got %h expected 04", ack6);
    end
    @(posedge clk); #1;
    tests++;
    if (ov6 !== 1'b1 || chan6 !== 3'd2 || z6 !== 8'h33) begin
      fails++;
      $display("FAIL in_range_out: got v=%b ch=%0d z=%h expected 1 2 33", ov6, chan6, z6);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; cycle("rr_reset"); rst = 1'b0;
    mode = 1'b1; valid = 8'hFF; ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle("rr_seq");
      tests++;
      if (chan !== 3'(i % 8)) begin
        fails++;
        $display("FAIL rr_order: got ch=%0d expected %0d", chan, i % 8);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 3'd3; valid = 8'h08; ready = 1'b1;
    cycle("bp_load");
    valid = 8'h10; mode = 1'b1; ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle("bp_hold");
      tests++;
      if (chan !== 3'd3 || ov !== 1'b1 || ack !== 8'h00) begin
        fails++;
        $display("FAIL bp_hold: got ch=%0d v=%b ack=%h expected 3 1 00", chan, ov, ack);
      end
    end
    ready = 1'b1;
    cycle("bp_release");
    tests++;
    if (chan !== 3'd4) begin
      fails++;
      $display("FAIL bp_next: got ch=%0d expected 4", chan);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b0; sel = 3'd6; valid = 8'h40; ready = 1'b0;
    cycle("mid_load");
    rst = 1'b1;
    cycle("mid_rst");
    tests++;
    if (ov !== 1'b0 || z !== 32'd0 || chan !== 3'd0) begin
      fails++;
      $display("FAIL mid_reset: got v=%b z=%h ch=%0d expected 0 0 0", ov, z, chan);
    end
    rst = 1'b0; mode = 1'b1; valid = 8'hFF; ready = 1'b1;
    cycle("mid_after");
    tests++;
    if (chan !== 3'd0 || ov !== 1'b1) begin
      fails++;
      $display("FAIL mid_restart: got ch=%0d v=%b expected 0 1", chan, ov);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      rand_data();
      mode  = 1'($urandom);
      sel   = 3'($urandom_range(0, 7));
      valid = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_ARB_LOCK_EN
      lock  = ($urandom_range(0, 3) == 0);
`endif
      cycle("random");
    end
`ifdef MUX_ARB_LOCK_EN
    lock = 1'b0;
`endif
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    rst = 1'b1; cycle("lock_reset"); rst = 1'b0;
    mode = 1'b1; valid = 8'h06; ready = 1'b1; lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("lock_hold");
      tests++;
      if (chan !== 3'd1) begin
        fails++;
        $display("FAIL lock_hold: got ch=%0d expected 1", chan);
      end
    end
    lock = 1'b0;
    cycle("lock_release");
    tests++;
    if (chan !== 3'd2) begin
      fails++;
      $display("FAIL lock_release: got ch=%0d expected 2", chan);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; c = '0; valid = '0; mode = 1'b0; sel = '0; ready = 1'b0;
    c6 = '0; valid6 = '0; mode6 = 1'b0; sel6 = '0; ready6 = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lock = 1'b0;
`endif
    m_z = '0; m_chan = '0; m_ptr = '0; m_valid = 1'b0; m_lock = 1'b0; m_lchan = '0;
    @(negedge clk);
    test_reset();
    test_direct();
    test_out_of_range();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter N, default 8, channel count (2..16).
REQ-003 SHALL derive localparam SEL_W = clog2(N) internally; it SHALL NOT be overridable.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port iC  input  N*WIDTH  channel data, channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port iValid  input  N  per-channel request.
REQ-008 SHALL have port oAck  output  N  one-hot, combinational; channel beat consumed this cycle.
REQ-009 SHALL have port iMode  input  1  0 = direct select, 1 = round-robin.
REQ-010 SHALL have port iSel  input  SEL_W  channel index used in direct mode.
REQ-011 SHALL have port oZ  output  WIDTH  registered selected data.
REQ-012 SHALL have port oChan  output  SEL_W  channel index of the beat in oZ.
REQ-013 SHALL have port oValid  output  1  oZ holds a valid beat.
REQ-014 SHALL have port iReady  input  1  downstream accepts oZ this cycle.

Function
REQ-015 Output register SHALL load when load_en = (~oValid | iReady) and a grant exists; latency iValid -> oValid is exactly 1 cycle.
REQ-016 Downstream transfer SHALL occur on cycles with oValid & iReady; if load_en is high and there is no grant, oValid SHALL clear next cycle.
REQ-017 With oValid=1 and iReady=0, oZ, oChan and oValid SHALL hold; oAck SHALL be all zero.
REQ-018 Direct mode: grant = iSel when iValid[iSel]=1 and iSel < N; if iSel >= N, no grant (no Z-drive, no X).
REQ-019 Round-robin mode: search SHALL start at ptr and wrap from N-1 to 0; the first asserted iValid wins.
REQ-020 ptr SHALL update to (granted+1) mod N only on a loaded grant in round-robin mode; direct-mode grants SHALL NOT move ptr.
REQ-021 oAck[k] SHALL be 1 iff channel k is granted and load_en=1; at most one bit SHALL be set.
REQ-022 An iMode change SHALL take effect in the same cycle's grant; ptr SHALL be preserved across mode changes.
REQ-023 Simultaneous downstream transfer and new load SHALL give back-to-back beats with no bubble.

Reset
REQ-024 On rst=1 at a clk edge: oZ=0, oChan=0, oValid=0, ptr=0; lock state cleared (if built).
REQ-025 During rst=1, oAck SHALL be all zero; a beat held mid-transfer SHALL be discarded.

Configuration
REQ-026 Macro MUX_ARB_LOCK_EN, when defined, SHALL add port iLock  input  1  (after iReady); in round-robin mode, while iLock=1 and a lock is held, only the last-granted channel SHALL be eligible. A lock SHALL be taken on any round-robin grant with iLock=1 and released on the first cycle with iLock=0.
REQ-027 Without MUX_ARB_LOCK_EN, port iLock and the lock state SHALL be absent; behaviour SHALL be pure REQ-019 arbitration.

Verification
REQ-028 Direct: iMode=0, iSel=5, iValid=8'h20, iC ch5=32'hDEADBEEF, iReady=1 -> oAck=8'h20 same cycle; next cycle oZ=32'hDEADBEEF, oChan=5, oValid=1.
REQ-029 Out of range: N=6, iMode=0, iSel=7, iValid=6'h3F -> oAck=0, oValid=0 next cycle.
REQ-030 Round-robin: iMode=1, iValid=8'hFF held, iReady=1 after reset -> oChan sequence 0,1,2,...,7,0 on consecutive cycles.
REQ-031 Backpressure: oValid=1, oChan=3, iReady=0 for 4 cycles, iValid=8'h10 -> oZ/oChan stable, oAck=0; first cycle with iReady=1 -> oAck=8'h10, next cycle oChan=4.
REQ-032 Reset mid-stream: rst=1 for one cycle while oValid=1, oChan=6 -> next cycle oValid=0, oZ=0, oChan=0; round-robin grant then starts at channel 0.
REQ-033 Lock (MUX_ARB_LOCK_EN): iMode=1, iValid=8'h06, iLock=1 after first grant to ch1 for 3 cycles -> oChan=1,1,1; iLock=0 -> next grant ch2.
